// File: rtl/arbiter_pkg.sv
// Shared types and constants for the registered N-way arbiter.
//   arb_state_e : arbiter ownership state (no owner / owner holds grant)
//   ARB_FIXED   : MODE value selecting fixed priority (index 0 highest)
//   ARB_RR      : MODE value selecting round-robin
package arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam int unsigned ARB_FIXED = 0;
   localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational rotating priority picker: first set request bit scanning
// upward from ptr and wrapping, returned as a one-hot vector.
//   requests : request vector
//   ptr      : index with highest priority this cycle (must be < N)
//   pick_oh  : one-hot selected requester (zero when nothing requests)
//   found    : at least one request is set
module arbiter_rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  requests,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick_oh,
   output logic          found
);

   logic [N-1:0] rot;
   logic [N-1:0] low;

   // Rotate so ptr lands on bit 0, isolate lowest set bit, rotate back.
   always_comb begin
      rot     = '0;
      pick_oh = '0;
      for (int unsigned i = 0; i < N; i++) begin
         rot[PW'(i)] = requests[PW'((i + 32'(ptr)) % N)];
      end
      low = rot & (~rot + N'(1));
      for (int unsigned i = 0; i < N; i++) begin
         pick_oh[PW'((i + 32'(ptr)) % N)] = low[PW'(i)];
      end
   end

   assign found = |requests;

endmodule

// File: rtl/arbiter_rr.sv
// Registered N-way arbiter, fixed-priority or round-robin, with downstream
// ready back-pressure and per-requester lock for multi-beat ownership.
//   clk         : clock
//   reset       : synchronous active-high reset
//   requests    : request vector, one bit per requester
//   lock        : lock[i]=1 keeps requester i as owner across accepted beats
//   ready       : downstream accepts the current beat
//   grants      : registered one-hot grant (zero when idle)
//   grant_valid : registered |grants
//   grant_id    : registered binary index of the owner (0 when idle)
module arbiter_rr
   import arbiter_pkg::*;
#(
   parameter  int unsigned N    = 4,
   parameter  int unsigned MODE = ARB_RR,
   localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  requests,
   input  logic [N-1:0]  lock,
   input  logic          ready,
   output logic [N-1:0]  grants,
   output logic          grant_valid,
   output logic [IW-1:0] grant_id
);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] id_q, id_d;
   logic [N-1:0]  grants_q, grants_d;
   logic          valid_q, valid_d;

   logic [N-1:0]  pick_oh;
   logic          found;
   logic [IW-1:0] pick_idx;
   logic          arb;

   arbiter_rr_pick #(
      .N  (N),
      .PW (IW)
   ) u_pick (
      .requests (requests),
      .ptr      (ptr_q),
      .pick_oh  (pick_oh),
      .found    (found)
   );

   // One-hot to binary index of the picked requester.
   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pick_oh[IW'(i)]) pick_idx = IW'(i);
      end
   end

   // Re-arbitrate when idle, when the owner withdrew, or when an unlocked
   // beat is accepted; otherwise the current grant holds.
   assign arb = (state_q == ARB_IDLE) || !requests[id_q] || (ready && !lock[id_q]);

   // Next-state and grant selection.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      grants_d = grants_q;
      valid_d  = valid_q;
      if (arb) begin
         if (found) begin
            state_d  = ARB_BUSY;
            grants_d = pick_oh;
            id_d     = pick_idx;
            valid_d  = 1'b1;
            if (MODE != ARB_FIXED) begin
               ptr_d = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
            end
         end else begin
            state_d  = ARB_IDLE;
            grants_d = '0;
            id_d     = '0;
            valid_d  = 1'b0;
         end
      end
   end

   // State and grant registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         grants_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         grants_q <= grants_d;
         valid_q  <= valid_d;
      end
   end

   assign grants      = grants_q;
   assign grant_valid = valid_q;
   assign grant_id    = id_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench: round-robin and fixed-priority instances driven with
// the same stimulus, each checked every cycle against a behavioural model
// through an expected-value queue, plus directed checks of key scenarios.
module tb_arbiter_rr;

   localparam int NR = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       ready;
   logic [3:0] requests;
   logic [3:0] lock;

   logic [3:0] g_rr, g_fx;
   logic       v_rr, v_fx;
   logic [1:0] id_rr, id_fx;

   typedef struct packed {
      logic [3:0] g;
      logic       v;
      logic [1:0] id;
   } exp_t;

   exp_t q_rr[$];
   exp_t q_fx[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Model state per instance: [0] fixed, [1] round-robin. Owner -1 = idle.
   int mg[2] = '{-1, -1};
   int mp[2] = '{0, 0};

   always #5 clk = ~clk;

   arbiter_rr #(.N(4), .MODE(1)) u_rr (
      .clk         (clk),
      .reset       (reset),
      .requests    (requests),
      .lock        (lock),
      .ready       (ready),
      .grants      (g_rr),
      .grant_valid (v_rr),
      .grant_id    (id_rr)
   );

   arbiter_rr #(.N(4), .MODE(0)) u_fx (
      .clk         (clk),
      .reset       (reset),
      .requests    (requests),
      .lock        (lock),
      .ready       (ready),
      .grants      (g_fx),
      .grant_valid (v_fx),
      .grant_id    (id_fx)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural arbiter: scan requesters in priority order from the pointer.
   task automatic model_step(input int m, input logic rst, input logic [3:0] rq,
                             input logic [3:0] lk, input logic rdy, output exp_t e);
      int own, p, pick, j;
      bit arb;
      own = mg[m];
      if (rst) begin
         mg[m] = -1;
         mp[m] = 0;
      end else begin
         arb = (own < 0);
         if (!arb) arb = !rq[2'(own)] || (rdy && !lk[2'(own)]);
         if (arb) begin
            p    = (m == 1) ? mp[m] : 0;
            pick = -1;
            for (int k = 0; k < NR; k++) begin
               j = (p + k) % NR;
               if (pick < 0 && rq[2'(j)]) pick = j;
            end
            mg[m] = pick;
            if (pick >= 0 && m == 1) mp[m] = (pick + 1) % NR;
         end
      end
      e.v  = (mg[m] >= 0);
      e.g  = e.v ? 4'(1 << mg[m]) : 4'b0000;
      e.id = e.v ? 2'(mg[m]) : 2'b00;
   endtask

   // Drive one cycle of stimulus, queue expectations, compare after the edge.
   task automatic step(input logic rst, input logic [3:0] rq, input logic [3:0] lk, input logic rdy);
      exp_t e;
      @(negedge clk);
      reset    = rst;
      requests = rq;
      lock     = lk;
      ready    = rdy;
      model_step(1, rst, rq, lk, rdy, e);
      q_rr.push_back(e);
      model_step(0, rst, rq, lk, rdy, e);
      q_fx.push_back(e);
      @(posedge clk);
      #1;
      e = q_rr.pop_front();
      check_eq("rr_grants", 32'(g_rr), 32'(e.g));
      check_eq("rr_valid",  32'(v_rr), 32'(e.v));
      check_eq("rr_id",     32'(id_rr), 32'(e.id));
      e = q_fx.pop_front();
      check_eq("fx_grants", 32'(g_fx), 32'(e.g));
      check_eq("fx_valid",  32'(v_fx), 32'(e.v));
      check_eq("fx_id",     32'(id_fx), 32'(e.id));
   endtask

   initial begin
      int seq[4] = '{1, 2, 3, 0};
      logic [3:0] rq, lk;
      reset    = 1'b1;
      requests = 4'b0000;
      lock     = 4'b0000;
      ready    = 1'b0;

      // Reset held with all requesting, first grant right after release.
      repeat (3) begin
         step(1'b1, 4'b1111, 4'b0000, 1'b1);
         check_eq("rst_grants", 32'(g_rr), 32'h0);
         check_eq("rst_valid",  32'(v_rr), 32'h0);
         check_eq("rst_id",     32'(id_rr), 32'h0);
      end
      step(1'b0, 4'b1111, 4'b0000, 1'b1);
      check_eq("first_grant", 32'(g_rr), 32'h1);

      // Round-robin rotation.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'b1111, 4'b0000, 1'b1);
         check_eq("rr_seq", 32'(id_rr), 32'(seq[i]));
      end

      // Fixed priority starves requester 3.
      repeat (4) begin
         step(1'b0, 4'b1010, 4'b0000, 1'b1);
         check_eq("fixed_pick", 32'(g_fx), 32'h2);
      end

      // Stall holds grant, release advances.
      step(1'b1, 4'b0000, 4'b0000, 1'b1);
      step(1'b0, 4'b0100, 4'b0000, 1'b1);
      check_eq("stall_start", 32'(g_rr), 32'h4);
      repeat (5) begin
         step(1'b0, 4'b1111, 4'b0000, 1'b0);
         check_eq("stall_hold", 32'(g_rr), 32'h4);
      end
      step(1'b0, 4'b1111, 4'b0000, 1'b1);
      check_eq("stall_next", 32'(g_rr), 32'h8);

      // Locked multi-beat ownership.
      step(1'b1, 4'b0000, 4'b0000, 1'b1);
      step(1'b0, 4'b0010, 4'b0000, 1'b1);
      check_eq("lock_own", 32'(id_rr), 32'h1);
      repeat (3) begin
         step(1'b0, 4'b1111, 4'b0010, 1'b1);
         check_eq("lock_hold", 32'(id_rr), 32'h1);
      end
      step(1'b0, 4'b1111, 4'b0000, 1'b1);
      check_eq("lock_release", 32'(id_rr), 32'h2);

      // Withdrawal under ready=0, then reset during a locked transfer.
      step(1'b1, 4'b0000, 4'b0000, 1'b1);
      step(1'b0, 4'b0001, 4'b0000, 1'b1);
      check_eq("wd_own", 32'(g_rr), 32'h1);
      step(1'b0, 4'b0100, 4'b0000, 1'b0);
      check_eq("wd_next", 32'(g_rr), 32'h4);
      step(1'b0, 4'b0000, 4'b0000, 1'b0);
      check_eq("wd_idle", 32'(g_rr), 32'h0);
      check_eq("wd_idle_valid", 32'(v_rr), 32'h0);
      step(1'b0, 4'b0010, 4'b0000, 1'b1);
      step(1'b0, 4'b1111, 4'b0010, 1'b1);
      check_eq("mid_lock", 32'(g_rr), 32'h2);
      step(1'b1, 4'b1111, 4'b0010, 1'b1);
      check_eq("mid_rst", 32'(g_rr), 32'h0);
      step(1'b0, 4'b1111, 4'b0000, 1'b1);
      check_eq("post_rst_ptr", 32'(g_rr), 32'h1);

      // Random traffic against the model.
      repeat (400) begin
         rq = 4'($urandom_range(0, 15));
         lk = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 31) == 0), rq, lk, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
